// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the MEM-stage data-memory responder:
//   - state_t          : responder FSM encoding (IDLE / WAIT / RESP)
//   - WORD_W           : data word width in bits
//   - word_index_width : number of address bits that select a word in an array
//                        of a given depth
// No ports; imported by dmem_responder and dmem_latency_counter.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A one-word array still needs a 1-bit index so the slice stays legal.
    function automatic int word_index_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// -----------------------------------------------------------------------------
// dmem_latency_counter
// Down-counter that times the outstanding access of the data-memory responder.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset (count clears to 0)
//   load       in   load load_value (takes priority over dec)
//   load_value in   WIDTH  value to load
//   dec        in   decrement by one; saturates at zero
//   zero       out  count is zero
// -----------------------------------------------------------------------------
module dmem_latency_counter
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage of the 5-stage RISC-V
// pipeline. Accepts one load/store from the EX/MEM outputs, completes it after
// LATENCY cycles and stalls the pipeline while the access is outstanding.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      cycles from acceptance to the commit edge (>= 1)
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   request present (EX/MEM mem_enable)
//   req_write   in   1 = store, 0 = load
//   req_addr    in   32  byte address; upper bits wrap modulo the array
//   req_wdata   in   32  store data
//   req_ready   out  responder can accept a request this cycle
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  32  load data (0 for stores), valid with resp_valid
//   stall       out  hold EX/MEM and upstream (req_valid & ~resp_valid)
//   misalign    out  only with DMEM_MISALIGN_EN: misaligned access flag,
//                    qualifies resp_valid
// Configuration macro: DMEM_MISALIGN_EN (misaligned requests skip the array
// and report misalign in the response cycle).
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              stall
`ifdef DMEM_MISALIGN_EN
   ,output logic              misalign
`endif
);

    localparam int IDX_W = word_index_width(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              accept;
    logic              commit;
    logic              access_ok;
    logic              mem_we;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Address bits above the word index never reach the array (wrap-around).
`ifdef DMEM_MISALIGN_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[WORD_W-1:IDX_W+2];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[WORD_W-1:IDX_W+2], req_addr[1:0]};
`endif

    assign accept = (state_q == IDLE) && req_valid;
    assign commit = (state_q == WAIT) && cnt_zero;

`ifdef DMEM_MISALIGN_EN
    logic mis_q, mis_d;
    assign access_ok = !mis_q;
    // Only meaningful in the response cycle; zero everywhere else.
    assign misalign  = mis_q && (state_q == RESP);
`else
    assign access_ok = 1'b1;
`endif

    dmem_latency_counter #(
        .WIDTH (CNT_W)
    ) u_latency_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (CNT_W'(LATENCY - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. RESP always returns to IDLE: a req_valid seen in RESP still
    // belongs to the instruction that is completing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = WAIT;
            WAIT:    if (cnt_zero)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. req_ready is gated with reset_n so it reads 0 while the
    // block is held in reset even though the state already sits in IDLE.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = reset_n;
                cnt_load  = req_valid;
            end
            WAIT: begin
                cnt_dec = !cnt_zero;
            end
            RESP: begin
                resp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // The pipeline advances in the response cycle itself.
    assign stall = req_valid && !resp_valid;

    // Request capture at acceptance; load data registered at the commit edge.
    always_comb begin
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_MISALIGN_EN
        mis_d   = mis_q;
`endif
        if (accept) begin
            write_d = req_write;
            idx_d   = req_addr[IDX_W+1:2];
            wdata_d = req_wdata;
`ifdef DMEM_MISALIGN_EN
            mis_d   = (req_addr[1:0] != 2'b00);
`endif
        end
        if (commit) begin
            rdata_d = (write_q || !access_ok) ? '0 : mem[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_MISALIGN_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_MISALIGN_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign resp_rdata = rdata_q;

    // Store commit. The array is not reset; because reset forces the state to
    // IDLE asynchronously, a store interrupted by reset never reaches here.
    assign mem_we = commit && write_q && access_ok;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders side by side (DEPTH_WORDS = 16, LATENCY = 4 and LATENCY = 1),
// driven with directed and random load/store traffic and compared against a
// word-array model of the memory plus the expected response timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 16;
    localparam int LAT0  = 4;
    localparam int LAT1  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        rv         [2];
    logic        rw         [2];
    logic [31:0] ra         [2];
    logic [31:0] rwd        [2];
    logic        ready      [2];
    logic        resp_valid [2];
    logic [31:0] rdata      [2];
    logic        stall      [2];
`ifdef DMEM_MISALIGN_EN
    logic        mis_o      [2];
`endif

    int checks      = 0;
    int errors      = 0;
    int cycle_count = 0;
    int lat_of [2];

    // Reference memory contents, one array per responder.
    logic [31:0] model [2][DEPTH];

    always @(posedge clk) cycle_count <= cycle_count + 1;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT0)
    ) dut_lat4 (
        .clk        (clk),
        .reset_n    (rst_n[0]),
        .req_valid  (rv[0]),
        .req_write  (rw[0]),
        .req_addr   (ra[0]),
        .req_wdata  (rwd[0]),
        .req_ready  (ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (rdata[0]),
        .stall      (stall[0])
`ifdef DMEM_MISALIGN_EN
       ,.misalign   (mis_o[0])
`endif
    );

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT1)
    ) dut_lat1 (
        .clk        (clk),
        .reset_n    (rst_n[1]),
        .req_valid  (rv[1]),
        .req_write  (rw[1]),
        .req_addr   (ra[1]),
        .req_wdata  (rwd[1]),
        .req_ready  (ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (rdata[1]),
        .stall      (stall[1])
`ifdef DMEM_MISALIGN_EN
       ,.misalign   (mis_o[1])
`endif
    );

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One complete access: drive the request at a falling edge, then watch the
    // responder cycle by cycle until the response. Returns the cycle number of
    // the acceptance cycle. Leaves req_valid high on return (response cycle).
    task automatic applyStimulus(input int sel, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, output int acc_cyc);
        int          idx;
        bit          mis;
        logic [31:0] exp_rdata;
        int          resp_cyc;
        int          stall_cnt;
        idx = int'((addr >> 2) % DEPTH);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_EN
        mis = (addr[1:0] != 2'b00);
`endif
        exp_rdata = (wr || mis) ? 32'h0 : model[sel][idx];

        @(negedge clk);
        rv[sel]  = 1'b1;
        rw[sel]  = wr;
        ra[sel]  = addr;
        rwd[sel] = wd;
        #1;
        acc_cyc = cycle_count;
        checkOutput("accept_ready", 32'(ready[sel]), 1);
        checkOutput("accept_no_resp", 32'(resp_valid[sel]), 0);
        stall_cnt = stall[sel] ? 1 : 0;
        resp_cyc  = -1;
        for (int c = 1; c <= lat_of[sel] + 4 && resp_cyc < 0; c++) begin
            @(negedge clk);
            #1;
            if (resp_valid[sel]) begin
                resp_cyc = c;
            end else begin
                if (stall[sel]) stall_cnt++;
                checkOutput("wait_ready", 32'(ready[sel]), 0);
            end
        end
        if (resp_cyc < 0) begin
            checkOutput("resp_timeout", 0, 1);
        end else begin
            checkOutput("resp_latency", resp_cyc - 1, lat_of[sel]);
            checkOutput("stall_cycles", stall_cnt, lat_of[sel] + 1);
            checkOutput("resp_stall", 32'(stall[sel]), 0);
            checkOutput("resp_ready", 32'(ready[sel]), 0);
            checkOutput(wr ? "store_rdata" : "load_rdata", rdata[sel], exp_rdata);
`ifdef DMEM_MISALIGN_EN
            checkOutput("misalign", 32'(mis_o[sel]), 32'(mis));
`endif
        end
        if (wr && !mis) model[sel][idx] = wd;
    endtask

    // Quiet cycles with no request; also confirms the response was one cycle.
    task automatic idleCycles(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rv[sel] = 1'b0;
            #1;
            checkOutput("idle_resp_valid", 32'(resp_valid[sel]), 0);
            checkOutput("idle_ready", 32'(ready[sel]), 1);
            checkOutput("idle_stall", 32'(stall[sel]), 0);
        end
    endtask

    // Store 0x1234 to 0x8 and pull reset in the second wait cycle: the store
    // must vanish and no response may appear.
    task automatic resetMidWait(input int sel);
        @(negedge clk);
        rv[sel]  = 1'b1;
        rw[sel]  = 1'b1;
        ra[sel]  = 32'h8;
        rwd[sel] = 32'h1234;
        @(negedge clk);
        @(negedge clk);
        rst_n[sel] = 1'b0;
        rv[sel]    = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(ready[sel]), 0);
        checkOutput("rst_resp_valid", 32'(resp_valid[sel]), 0);
        checkOutput("rst_rdata", rdata[sel], 0);
        checkOutput("rst_stall", 32'(stall[sel]), 0);
        @(negedge clk);
        rst_n[sel] = 1'b1;
        #1;
        checkOutput("rst_release_ready", 32'(ready[sel]), 1);
        for (int c = 0; c < lat_of[sel] + 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("rst_no_resp", 32'(resp_valid[sel]), 0);
            checkOutput("rst_rdata_hold", rdata[sel], 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          a0;
        int          a1;
        logic [31:0] addr;
        bit          wr;

        lat_of[0] = LAT0;
        lat_of[1] = LAT1;
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0;
            rv[s]    = 1'b0;
            rw[s]    = 1'b0;
            ra[s]    = 32'h0;
            rwd[s]   = 32'h0;
        end

        // Reset state; stall simply follows req_valid while held in reset.
        rv[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("reset_ready", 32'(ready[s]), 0);
            checkOutput("reset_resp_valid", 32'(resp_valid[s]), 0);
            checkOutput("reset_rdata", rdata[s], 0);
        end
        checkOutput("reset_stall_follows_hi", 32'(stall[0]), 1);
        checkOutput("reset_stall_follows_lo", 32'(stall[1]), 0);
        rv[0] = 1'b0;
        #1;
        checkOutput("reset_stall_follows_drop", 32'(stall[0]), 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        checkOutput("release_ready0", 32'(ready[0]), 1);
        checkOutput("release_ready1", 32'(ready[1]), 1);

        // Give every word a known value through the interface.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < DEPTH; w++) begin
                applyStimulus(s, 1'b1, 32'(w * 4), $urandom, a0);
            end
            idleCycles(s, 1);
        end

        $display("[TB] store then load, LATENCY=4");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, a0);
        idleCycles(0, 2);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, a0);
        idleCycles(0, 1);

        $display("[TB] address wrap");
        applyStimulus(0, 1'b1, 32'h40, 32'hA5A5A5A5, a0);
        idleCycles(0, 1);
        applyStimulus(0, 1'b0, 32'h00, 32'h0, a0);
        idleCycles(0, 1);

        $display("[TB] reset during wait");
        applyStimulus(0, 1'b1, 32'h8, 32'h0, a0);
        idleCycles(0, 1);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, a0);
        idleCycles(0, 1);
        resetMidWait(0);
        idleCycles(0, 1);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, a0);
        idleCycles(0, 1);

        // req_valid held through the response; the next request is accepted
        // in the cycle after it: acceptance, LATENCY wait cycles, response.
        $display("[TB] hold through response");
        applyStimulus(0, 1'b0, 32'h20, 32'h0, a0);
        applyStimulus(0, 1'b0, 32'h24, 32'h0, a1);
        checkOutput("b2b_spacing_lat4", a1 - a0, LAT0 + 2);
        idleCycles(0, 1);

`ifdef DMEM_MISALIGN_EN
        $display("[TB] misaligned store");
        applyStimulus(0, 1'b1, 32'h6, 32'hFFFFFFFF, a0);
        idleCycles(0, 1);
        applyStimulus(0, 1'b0, 32'h4, 32'h0, a0);
        idleCycles(0, 1);
`endif

        $display("[TB] back-to-back loads, LATENCY=1");
        applyStimulus(1, 1'b1, 32'h0, 32'h11, a0);
        idleCycles(1, 1);
        applyStimulus(1, 1'b1, 32'h4, 32'h22, a0);
        idleCycles(1, 1);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, a0);
        applyStimulus(1, 1'b0, 32'h4, 32'h0, a1);
        checkOutput("b2b_spacing_lat1", a1 - a0, LAT1 + 2);
        idleCycles(1, 1);

        $display("[TB] random traffic");
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40; i++) begin
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
                wr = 1'($urandom_range(0, 1));
                applyStimulus(s, wr, addr, $urandom, a0);
                if ($urandom_range(0, 2) != 0) idleCycles(s, $urandom_range(1, 2));
            end
            idleCycles(s, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
